// File: rtl/controle_medida_hcsr04.sv
`default_nettype none
// ============================================================================
// Module      : controle_medida_hcsr04
// Description : Measurement sequencer for an HC-SR04 ultrasonic sensor.
//               Issues the trigger pulse, forwards the synchronised echo to
//               an external contador_cm block, waits for its result and
//               latches the distance; aborts with a sticky error flag when
//               the echo or the counter result takes too long.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_medida_hcsr04 #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  input  logic        pronto_cm,
  input  logic [11:0] medida_cm,
  output logic        trigger,
  output logic        zera_cm,
  output logic        pulso_cm,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  // Timeout counter gets a little headroom: after it reaches its limit the
  // FSM may pass through one or two more counting states before ERRO.
  localparam int C_TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES + 1) : 1;
  localparam int C_TMO_W  = $clog2(TIMEOUT_CYCLES + 4);

  localparam logic [C_TRIG_W-1:0] c_trig_last = C_TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [C_TMO_W-1:0]  c_tmo_last  = C_TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] c_inicial     = 4'd0;
  localparam logic [3:0] c_prepara     = 4'd1;
  localparam logic [3:0] c_trigger     = 4'd2;
  localparam logic [3:0] c_espera_echo = 4'd3;
  localparam logic [3:0] c_medindo     = 4'd4;
  localparam logic [3:0] c_espera_cm   = 4'd5;
  localparam logic [3:0] c_armazena    = 4'd6;
  localparam logic [3:0] c_final       = 4'd7;
  localparam logic [3:0] c_erro        = 4'd15;

  logic                r_echo_meta;
  logic                r_echo_s;
  logic [3:0]          r_estado;
  logic [3:0]          w_proximo;
  logic [C_TRIG_W-1:0] r_cnt_trig;
  logic [C_TMO_W-1:0]  r_cnt_tmo;
  logic [11:0]         r_medida;
  logic                r_erro;
  logic                w_tmo_fim;
  logic                w_contando;

  // Once the limit is reached every counting state leaves immediately,
  // so ">=" also covers entering a later stage with the budget exhausted.
  assign w_tmo_fim  = (r_cnt_tmo >= c_tmo_last);
  assign w_contando = (r_estado == c_espera_echo) || (r_estado == c_medindo) ||
                      (r_estado == c_espera_cm);

  // Two-flop synchroniser for the asynchronous echo line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
    end
  end

  // Next-state logic; the completion event wins over the timeout in each wait state
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      c_inicial:     if (medir) w_proximo = c_prepara;
      c_prepara:     w_proximo = c_trigger;
      c_trigger:     if (r_cnt_trig >= c_trig_last) w_proximo = c_espera_echo;
      c_espera_echo: begin
        if (r_echo_s)       w_proximo = c_medindo;
        else if (w_tmo_fim) w_proximo = c_erro;
      end
      c_medindo: begin
        if (!r_echo_s)      w_proximo = c_espera_cm;
        else if (w_tmo_fim) w_proximo = c_erro;
      end
      c_espera_cm: begin
        if (pronto_cm)      w_proximo = c_armazena;
        else if (w_tmo_fim) w_proximo = c_erro;
      end
      c_armazena:    w_proximo = c_final;
      c_final:       w_proximo = c_inicial;
      c_erro:        w_proximo = c_inicial;
      default:       w_proximo = c_inicial;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= c_inicial;
    else       r_estado <= w_proximo;
  end

  // Trigger width and timeout counters, both cleared in PREPARA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_trig <= '0;
      r_cnt_tmo  <= '0;
    end else if (r_estado == c_prepara) begin
      r_cnt_trig <= '0;
      r_cnt_tmo  <= '0;
    end else begin
      if (r_estado == c_trigger) r_cnt_trig <= r_cnt_trig + C_TRIG_W'(1);
      if (w_contando)            r_cnt_tmo  <= r_cnt_tmo + C_TMO_W'(1);
    end
  end

  // Result register and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_medida <= 12'h000;
      r_erro   <= 1'b0;
    end else begin
      if (r_estado == c_armazena) r_medida <= medida_cm;
      if (r_estado == c_prepara)  r_erro   <= 1'b0;
      else if (r_estado == c_erro) r_erro  <= 1'b1;
    end
  end

  assign trigger   = (r_estado == c_trigger);
  assign zera_cm   = (r_estado == c_prepara);
  assign pronto    = (r_estado == c_final);
  assign pulso_cm  = r_echo_s;
  assign medida    = r_medida;
  assign erro      = r_erro;
  assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_medida_hcsr04.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_medida_hcsr04
// Description : Self-checking bench for controle_medida_hcsr04. Each
//               measurement is planned as a timeline of state intervals
//               computed from the sequencer's timing rules; a compare process
//               checks every output against that timeline each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_medida_hcsr04;

  localparam int T   = 5;
  localparam int TO  = 100;
  localparam int INF = 1 << 28;
  localparam int N   = 16384;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medir = 1'b0;
  logic        echo = 1'b0;
  logic        pronto_cm = 1'b0;
  logic [11:0] medida_cm = 12'h000;
  logic        trigger, zera_cm, pulso_cm, pronto, erro;
  logic [11:0] medida;
  logic [3:0]  db_estado;

  controle_medida_hcsr04 #(.TRIGGER_CYCLES(T), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo),
    .pronto_cm(pronto_cm), .medida_cm(medida_cm), .trigger(trigger),
    .zera_cm(zera_cm), .pulso_cm(pulso_cm), .medida(medida),
    .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int          cyc = 0;
  bit          eh      [0:N-1];
  logic [3:0]  exp_st  [0:N-1];
  logic [11:0] exp_med [0:N-1];
  bit          exp_err [0:N-1];
  int          tests = 0, fails = 0;
  bit          check_en = 1'b0;
  int          n_trig, n_zera, n_pronto, first_trig, first_erro_st;
  logic [11:0] m_med = 12'h000;
  bit          m_err = 1'b0;

  // Cycle counter plus history of the raw echo seen at each rising edge
  always @(posedge clock) begin
    eh[cyc] = echo;
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the planned timeline
  always @(negedge clock) begin
    logic [3:0] es;
    bit ep, ok;
    if (check_en) begin
      es = exp_st[cyc];
      ep = (cyc >= 2) ? eh[cyc-2] : 1'b0;
      ok = (db_estado == es) && (trigger == (es == 4'd2)) && (zera_cm == (es == 4'd1)) &&
           (pronto == (es == 4'd7)) && (medida == exp_med[cyc]) &&
           (erro == exp_err[cyc]) && (pulso_cm == ep);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cycle_check @%0d: got estado=%0d trig=%b zera=%b pronto=%b medida=%h erro=%b pulso=%b; expected estado=%0d trig=%b zera=%b pronto=%b medida=%h erro=%b pulso=%b",
                 cyc, db_estado, trigger, zera_cm, pronto, medida, erro, pulso_cm,
                 es, es == 4'd2, es == 4'd1, es == 4'd7, exp_med[cyc], exp_err[cyc], ep);
      end
      if (trigger) begin
        if (n_trig == 0) first_trig = cyc;
        n_trig++;
      end
      if (zera_cm) n_zera++;
      if (pronto) n_pronto++;
      if (db_estado == 4'd15 && first_erro_st < 0) first_erro_st = cyc;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic clr_stats();
    n_trig = 0; n_zera = 0; n_pronto = 0; first_trig = -1; first_erro_st = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_st[cyc] = 4'd0; exp_med[cyc] = m_med; exp_err[cyc] = m_err;
      medir = 1'b0; echo = 1'b0;
      pronto_cm = 1'($urandom_range(0, 1)); medida_cm = 12'($urandom);
      step();
    end
  endtask

  // One measurement: echo raised a cycles into the echo wait, held w cycles,
  // pronto_cm p cycles into the counter wait. Stage timing:
  //   echo_s lags the raw echo by 2 cycles; each wait stage ends on its event
  //   or, once the count from the start of the echo wait has reached TO-1,
  //   goes to ERRO on the following cycle.
  task automatic run_meas(input int a, input int w, input int p, input logic [11:0] val,
                          input bit no_echo, input bit noisy);
    int k0, e, lim, ls, rise, fall, pr, m, c, aa, errc, endc;
    k0 = cyc;
    if (k0 + 400 >= N) begin
      $display("FAIL plan_space: got cycle %0d expected below %0d", k0, N - 400);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
    end
    e = k0 + 2 + T; lim = e + TO - 1;
    m = INF; c = INF; aa = INF; errc = INF; pr = INF;
    rise = no_echo ? INF : e + a + 2;
    if (rise <= lim) begin
      m = rise + 1; ls = (m > lim) ? m : lim;
      fall = e + a + w + 2;
      if (fall <= ls) begin
        c = fall + 1; ls = (c > lim) ? c : lim;
        pr = c + p;
        if (pr <= ls) aa = pr + 1;
        else errc = ls + 1;
      end else errc = ls + 1;
    end else errc = lim + 1;
    endc = (aa != INF) ? aa + 2 : errc + 1;
    if (!no_echo && e + a + w + 2 > endc) endc = e + a + w + 2;
    for (int t = k0; t <= endc; t++) begin
      logic [3:0] st;
      st = 4'd0;
      if (t == k0 + 1) st = 4'd1;
      else if (t >= k0 + 2 && t < e) st = 4'd2;
      else if (t >= e && t < m && t < errc) st = 4'd3;
      else if (t >= m && t < c && t < errc) st = 4'd4;
      else if (t >= c && t < aa && t < errc) st = 4'd5;
      else if (t == aa) st = 4'd6;
      else if (t == aa + 1) st = 4'd7;
      else if (t == errc) st = 4'd15;
      exp_st[t]  = st;
      exp_med[t] = (aa != INF && t >= aa + 1) ? val : m_med;
      exp_err[t] = (errc != INF && t >= errc + 1) ? 1'b1 : ((t >= k0 + 2) ? 1'b0 : m_err);
    end
    for (int t = k0; t <= endc; t++) begin
      medir     = (t == k0) || (noisy && exp_st[t] != 4'd0 && $urandom_range(0, 1) == 1);
      echo      = !no_echo && t >= e + a && t < e + a + w;
      pronto_cm = (exp_st[t] == 4'd5) ? (t == pr) : 1'($urandom_range(0, 1));
      medida_cm = (t == aa) ? val : 12'($urandom);
      step();
    end
    medir = 1'b0; echo = 1'b0;
    m_med = exp_med[endc];
    m_err = exp_err[endc];
  endtask

  initial begin
    int k;
    clr_stats();
    repeat (3) step();
    chk("reset_estado", db_estado, 0);
    chk("reset_medida", medida, 0);
    chk("reset_outs", {trigger, zera_cm, pronto, erro, pulso_cm}, 0);
    reset = 1'b0;
    check_en = 1'b1;
    idle(10);
    chk("idle_estado", db_estado, 0);
    chk("idle_medida", medida, 0);

    // Basic good measurement, pinned with hand-computed values
    clr_stats(); k = cyc;
    run_meas(3, 20, 2, 12'h123, 1'b0, 1'b0);
    chk("trig_width", n_trig, 5);
    chk("zera_width", n_zera, 1);
    chk("pronto_count", n_pronto, 1);
    chk("trig_latency", first_trig - k, 2);
    chk("medida_123", medida, 12'h123);
    chk("erro_clear", erro, 0);
    idle(3);

    // Echo never arrives: ERRO 100 counted cycles after the echo wait begins
    clr_stats(); k = cyc;
    run_meas(0, 0, 0, 12'h000, 1'b1, 1'b0);
    chk("timeout_at", first_erro_st - k, 107);
    chk("erro_set", erro, 1);
    chk("medida_kept", medida, 12'h123);
    chk("no_pronto_err", n_pronto, 0);
    idle(5);
    chk("erro_sticky", erro, 1);

    // Recovery after an error
    clr_stats();
    run_meas(5, 10, 0, 12'h045, 1'b0, 1'b0);
    chk("erro_recovered", erro, 0);
    chk("medida_045", medida, 12'h045);
    chk("pronto_once", n_pronto, 1);
    idle(2);

    // medir toggling outside INICIAL is ignored
    clr_stats();
    run_meas(10, 30, 3, 12'h777, 1'b0, 1'b1);
    chk("noisy_pronto", n_pronto, 1);
    chk("noisy_medida", medida, 12'h777);
    idle(2);

    // Timeout boundaries: echo_s at the last counted cycle, one later,
    // pronto_cm at the last counted cycle, one later
    run_meas(97, 5, 0, 12'h311, 1'b0, 1'b0); idle(2);
    run_meas(98, 5, 0, 12'h322, 1'b0, 1'b0); idle(2);
    run_meas(10, 20, 66, 12'h456, 1'b0, 1'b0); idle(2);
    chk("edge_pronto_ok", medida, 12'h456);
    run_meas(10, 20, 67, 12'h654, 1'b0, 1'b0); idle(2);
    chk("edge_pronto_late", erro, 1);

    for (int i = 0; i < 25; i++) begin
      run_meas($urandom_range(0, 105), $urandom_range(1, 60), $urandom_range(0, 50),
               12'($urandom), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4));
    end

    // Reset in the middle of MEDINDO
    run_meas(2, 10, 1, 12'h987, 1'b0, 1'b0);
    idle(2);
    check_en = 1'b0;
    pronto_cm = 1'b0;
    medir = 1'b1; step(); medir = 1'b0;
    for (int i = 0; i < 20 && db_estado != 4'd3; i++) step();
    echo = 1'b1;
    for (int i = 0; i < 10 && db_estado != 4'd4; i++) step();
    chk("reach_medindo", db_estado, 4);
    chk("pre_reset_medida", medida, 12'h987);
    #2;
    reset = 1'b1; echo = 1'b0;
    #1;
    chk("abort_estado", db_estado, 0);
    chk("abort_medida", medida, 0);
    chk("abort_outs", {trigger, zera_cm, pronto, erro, pulso_cm}, 0);
    step(); step();
    reset = 1'b0;
    m_med = 12'h000; m_err = 1'b0;
    clr_stats();
    check_en = 1'b1;
    idle(5);
    chk("abort_no_pronto", n_pronto, 0);
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got no end of run, expected completion before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
`default_nettype wire
